niosprocessorlab_nios2_qsys_0_div_cell: RTL

NIOSPROCESSORLAB_NIOS2_QSYS_0_DIV_CELL -- requirements
Module: NIOSProcessorLab_nios2_qsys_0_div_cell

---
 rtl/niosprocessorlab_nios2_qsys_0_div_cell.sv | 91 +++++++++
 1 files changed

// File: rtl/niosprocessorlab_nios2_qsys_0_div_cell.sv
// niosprocessorlab_nios2_qsys_0_div_cell: 32-bit restoring divider, fixed 34-cycle latency.
// Define NIOSPROCESSORLAB_DIV_SIGNED_EN to honour A_div_signed; otherwise every divide is unsigned.
module niosprocessorlab_nios2_qsys_0_div_cell (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        A_div_start,
    input  logic [31:0] A_div_src1,
    input  logic [31:0] A_div_src2,
    input  logic        A_div_signed,
    output logic        A_div_busy,
    output logic        A_div_done,
    output logic [31:0] A_div_quot,
    output logic [31:0] A_div_rem
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] pr, qr, dvs, dvd, mag1, mag2, q_fix, r_fix;
    logic [32:0] pr_sh, diff;
    assign pr_sh = {pr, qr[31]};
    assign diff  = pr_sh - {1'b0, dvs};
`ifdef NIOSPROCESSORLAB_DIV_SIGNED_EN
    logic neg_q, neg_r, s1_neg, s2_neg;
    assign s1_neg = A_div_signed & A_div_src1[31];
    assign s2_neg = A_div_signed & A_div_src2[31];
    assign mag1   = s1_neg ? -A_div_src1 : A_div_src1;
    assign mag2   = s2_neg ? -A_div_src2 : A_div_src2;
    assign q_fix  = neg_q ? -qr : qr;
    assign r_fix  = neg_r ? -pr : pr;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && A_div_start) begin
            neg_q <= s1_neg ^ s2_neg;
            neg_r <= s1_neg;
        end
    end
`else
    logic unused_signed;
    assign unused_signed = A_div_signed;
    assign mag1  = A_div_src1;
    assign mag2  = A_div_src2;
    assign q_fix = qr;
    assign r_fix = pr;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            pr         <= 32'd0;
            qr         <= 32'd0;
            dvs        <= 32'd0;
            dvd        <= 32'd0;
            A_div_busy <= 1'b0;
            A_div_done <= 1'b0;
            A_div_quot <= 32'd0;
            A_div_rem  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (A_div_start) begin
                    state      <= CALC;
                    cnt        <= 5'd0;
                    pr         <= 32'd0;
                    qr         <= mag1;
                    dvs        <= mag2;
                    dvd        <= A_div_src1;
                    A_div_busy <= 1'b1;
                end
                CALC: begin
                    // Quotient bits shift in behind the dividend bits being consumed
                    pr    <= diff[32] ? pr_sh[31:0] : diff[31:0];
                    qr    <= {qr[30:0], ~diff[32]};
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'd31) ? FIX : CALC;
                end
                FIX: begin
                    A_div_quot <= (dvs == 32'd0) ? 32'hFFFF_FFFF : q_fix;
                    A_div_rem  <= (dvs == 32'd0) ? dvd : r_fix;
                    A_div_done <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    A_div_done <= 1'b0;
                    A_div_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
